// File: rtl/fetch_prefetch_stage.sv
// fetch_prefetch_stage: sequential-PC instruction fetch with credit-limited prefetch FIFO feeding IF/ID
module fetch_prefetch_stage #(
  parameter int DEPTH = 4,
  parameter int PC_W = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            id_stall,
  output logic [31:0]     instr_ID,
  output logic [PC_W-1:0] PC_ID,
  output logic            valid_ID
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [PC_W-1:0] pc, rsp_pc;
  logic [CW-1:0] outstanding, drop, count;
  logic [AW-1:0] wptr, rptr;
  logic [31:0] fifo_instr [DEPTH];
  logic [PC_W-1:0] fifo_pc [DEPTH];
  logic [CW:0] credit;
  logic hs, push, pop;
  // Requests are only issued while in-flight plus buffered words leave room in the FIFO
  always_comb begin
    credit = {1'b0, outstanding} + {1'b0, count};
    imem_req_valid = reset & ~redirect & (credit < (CW+1)'(DEPTH));
    imem_addr = pc;
    hs = imem_req_valid & imem_req_ready;
    push = imem_rsp_valid & ~redirect & (drop == '0);
    pop = ~redirect & ~id_stall & (count != '0);
  end
  // Fetch PC, response PC, in-flight/drop accounting and FIFO pointers
  always_ff @(posedge clk)
    if (!reset) begin
      pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      outstanding <= outstanding + CW'(hs) - CW'(imem_rsp_valid);
      if (redirect) begin
        pc <= redirect_pc;
        rsp_pc <= redirect_pc;
        drop <= outstanding - CW'(imem_rsp_valid);
        count <= '0;
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (hs) pc <= pc + PC_W'(4);
        if (push) rsp_pc <= rsp_pc + PC_W'(4);
        if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
        wptr <= wptr + AW'(push);
        rptr <= rptr + AW'(pop);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  // FIFO storage: each accepted word is tagged with the PC it was fetched from
  always_ff @(posedge clk)
    if (push) begin
      fifo_instr[wptr] <= imem_rsp_data;
      fifo_pc[wptr] <= rsp_pc;
    end
  // IF/ID register: redirect squashes, stall holds, otherwise pop head or insert a bubble
  always_ff @(posedge clk)
    if (!reset) begin
      valid_ID <= 1'b0;
      instr_ID <= '0;
      PC_ID <= '0;
    end else if (redirect) begin
      valid_ID <= 1'b0;
      instr_ID <= '0;
    end else if (!id_stall) begin
      valid_ID <= pop;
      instr_ID <= pop ? fifo_instr[rptr] : '0;
      if (pop) PC_ID <= fifo_pc[rptr];
    end
  // A response with nothing in flight means the memory broke the protocol
  always_ff @(posedge clk)
    if (reset) assert (!(imem_rsp_valid && outstanding == '0));
endmodule

// File: doc/fetch_prefetch_stage.md
Name: fetch_prefetch_stage

Overview:
Instruction-fetch stage of the 5-stage 64-bit pipeline, directly upstream of the decode stage. It generates sequential PCs and issues requests to a variable-latency instruction memory. Returned words are buffered in a small in-order prefetch FIFO, which drives the IF/ID pipeline register (instruction plus PC) consumed by decode. Branch redirects from ID flush the stage, and ID stalls freeze its output.

Parameters:
DEPTH, 4, prefetch FIFO entries and maximum in-flight requests; power of 2, minimum 2.
PC_W, 64, program-counter width.
RESET_PC, 0, first fetch address after reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request this cycle.
imem_addr  output  PC_W  request address (current fetch PC).
imem_rsp_valid  input  1  response valid; responses return in request order.
imem_rsp_data  input  32  returned instruction word.
redirect  input  1  branch taken in ID; flush and refetch.
redirect_pc  input  PC_W  branch target.
id_stall  input  1  decode cannot accept; hold IF/ID.
instr_ID  output  32  IF/ID instruction.
PC_ID  output  PC_W  IF/ID PC of instr_ID.
valid_ID  output  1  instr_ID is a real instruction (0 = bubble).

Behaviour:
- Reset (reset == 0 at an edge) sets:
  - fetch PC = RESET_PC
  - FIFO empty, outstanding = 0, drop = 0
  - valid_ID = 0, instr_ID = 0, PC_ID = 0
- imem_req_valid is 0 while reset is low.
- Credit rule: imem_req_valid = reset & ~redirect & (outstanding + fifo_count < DEPTH). The FIFO therefore never overflows, and rsp_valid is never dropped for lack of space.
- Request handshake occurs when imem_req_valid & imem_req_ready. On handshake: fetch PC += 4 (wraps modulo 2^PC_W); outstanding += 1.
- imem_addr always equals fetch PC, including when valid is low.
- Response handling:
  - outstanding -= 1 on each imem_rsp_valid.
  - If drop > 0: the word is discarded and drop -= 1.
  - Otherwise the word is pushed with its PC. Each FIFO entry holds {instr, pc}; pc is tracked by a response-PC register that starts at fetch PC after reset or redirect and increments by 4 per accepted response.
- Simultaneous request handshake and response in one cycle: outstanding is unchanged.
- IF/ID update, each edge when reset is high:
  - redirect = 1: valid_ID = 0, instr_ID = 0, PC_ID unchanged. Overrides id_stall.
  - else id_stall = 1: IF/ID holds; FIFO is not popped.
  - else FIFO non-empty: pop head into instr_ID/PC_ID; valid_ID = 1.
  - else: valid_ID = 0, instr_ID = 0 (NOP bubble).
- No bypass path. A word pushed at edge t is at the FIFO head after t and reaches IF/ID at edge t+1 at the earliest. Minimum response-to-ID latency is 2 edges.
- Push and pop in the same cycle are allowed; fifo_count is unchanged.
- Redirect, same edge:
  - fetch PC = redirect_pc; response-PC register = redirect_pc.
  - FIFO cleared.
  - drop = outstanding after this cycle's response accounting, i.e. outstanding minus (rsp_valid this cycle). Any same-cycle response is also discarded.
  - No request is issued in the redirect cycle.
  - Fetching resumes the next cycle.
- Redirect while drop > 0: drop is set to the new outstanding total; never accumulated twice.
- redirect_pc is not checked for alignment; low 2 bits pass through.
- imem_rsp_valid with outstanding == 0 is illegal; assert in simulation, ignore in RTL.
- Counter widths: outstanding, drop and fifo_count are clog2(DEPTH)+1 bits.

Test Plan:
- Reset then 1-cycle memory (ready = 1, rsp the cycle after request, word = addr | 0xD5000000), no stall → imem_addr 0, 4, 8…; valid_ID first rises 3 edges after reset release with PC_ID = 0, then one instruction per cycle with PC_ID incrementing by 4.
- Memory stops responding (ready = 1) → exactly 4 requests issued (addrs 0x0–0xC), then imem_req_valid = 0 until a response arrives.
- id_stall held 5 cycles with the FIFO full → instr_ID/PC_ID constant, no requests issued. Stall released → 4 buffered instructions drain in PC order with no gaps.
- 3 requests outstanding, redirect with redirect_pc = 0x400 → next valid_ID PC_ID = 0x400. The 3 stale responses are dropped; no PC 0x8–0x10 instruction ever appears with valid_ID = 1.
- redirect and id_stall both high in one cycle, response arriving the same cycle → valid_ID = 0 next edge, that response is dropped, imem_req_valid = 0 that cycle.
- reset driven low mid-stream with the FIFO half full → next edge valid_ID = 0, imem_addr = RESET_PC; after release, fetch restarts cleanly from RESET_PC.
